// File: rtl/fetch_pkg.sv
// Shared types and default widths for the instruction fetch unit.
package fetch_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    typedef enum logic {
        RUN,
        DRAIN
    } fetch_state_t;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] pc;
        logic [DEF_DATA_W-1:0] data;
        logic                  filled;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// In-order fetch ring: entries are allocated at grant, filled at rvalid
// and popped toward decode, tracked by three wrap-bit pointers.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = 4,
    localparam int IW    = $clog2(DEPTH),
    localparam int PW    = IW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_alloc,
    input  logic [ADDR_W-1:0] i_alloc_pc,
    input  logic              i_fill,
    input  logic [DATA_W-1:0] i_fill_data,
    input  logic              i_pop,
    input  logic              i_flush,
    output logic              o_rd_filled,
    output logic [ADDR_W-1:0] o_rd_pc,
    output logic [DATA_W-1:0] o_rd_data,
    output logic [PW-1:0]     o_occupancy,
    output logic [PW-1:0]     o_outstanding
);

    logic [ADDR_W-1:0] r_pc   [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [DEPTH-1:0]  r_filled;
    logic [PW-1:0]     r_alloc_ptr;
    logic [PW-1:0]     r_fill_ptr;
    logic [PW-1:0]     r_rd_ptr;

    logic [IW-1:0] w_alloc_idx;
    logic [IW-1:0] w_fill_idx;
    logic [IW-1:0] w_rd_idx;

    assign w_alloc_idx = r_alloc_ptr[IW-1:0];
    assign w_fill_idx  = r_fill_ptr[IW-1:0];
    assign w_rd_idx    = r_rd_ptr[IW-1:0];

    // Flush collapses the ring onto alloc_ptr; nothing is allocated that cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alloc_ptr <= '0;
            r_fill_ptr  <= '0;
            r_rd_ptr    <= '0;
            r_filled    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_pc[i]   <= '0;
                r_data[i] <= '0;
            end
        end else if (i_flush) begin
            r_rd_ptr   <= r_alloc_ptr;
            r_fill_ptr <= r_alloc_ptr;
            r_filled   <= '0;
        end else begin
            if (i_alloc) begin
                r_pc[w_alloc_idx]     <= i_alloc_pc;
                r_filled[w_alloc_idx] <= 1'b0;
                r_alloc_ptr           <= r_alloc_ptr + PW'(1);
            end
            if (i_fill) begin
                r_data[w_fill_idx]   <= i_fill_data;
                r_filled[w_fill_idx] <= 1'b1;
                r_fill_ptr           <= r_fill_ptr + PW'(1);
            end
            if (i_pop) begin
                r_filled[w_rd_idx] <= 1'b0;
                r_rd_ptr           <= r_rd_ptr + PW'(1);
            end
        end
    end

    assign o_rd_filled   = r_filled[w_rd_idx];
    assign o_rd_pc       = r_pc[w_rd_idx];
    assign o_rd_data     = r_data[w_rd_idx];
    assign o_occupancy   = r_alloc_ptr - r_rd_ptr;
    assign o_outstanding = r_alloc_ptr - r_fill_ptr;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: req/gnt toward imem, in-order buffer, flush drain FSM.
// Define IFETCH_PERF_CNT_EN to add stall_full_cnt / drop_cnt_total outputs.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
`ifdef IFETCH_PERF_CNT_EN
    output logic [31:0]       stall_full_cnt,
    output logic [31:0]       drop_cnt_total,
`endif
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              pc_valid,
    output logic              pc_ready,
    input  logic              flush,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc
);

    localparam int PW = $clog2(DEPTH) + 1;

    fetch_state_t r_state;
    logic [PW-1:0] r_drop_cnt;

    logic [PW-1:0] w_occupancy;
    logic [PW-1:0] w_outstanding;
    logic [PW-1:0] w_drop_next;
    logic          w_run;
    logic          w_full;
    logic          w_req;
    logic          w_alloc;
    logic          w_fill;
    logic          w_pop;
    logic          w_flush;
    logic          w_rd_filled;

    assign w_run   = (r_state == RUN);
    assign w_full  = (w_occupancy == PW'(DEPTH));
    assign w_req   = !rst && w_run && pc_valid && !flush && !w_full;
    assign w_alloc = w_req && imem_gnt;
    assign w_flush = w_run && flush;
    assign w_fill  = w_run && !flush && imem_rvalid;
    assign w_pop   = instr_valid && instr_ready;

    assign imem_req    = w_req;
    assign imem_addr   = pc_in;
    assign pc_ready    = w_alloc;
    assign instr_valid = !rst && w_rd_filled && (w_occupancy != '0) && !flush;

    // A response arriving in the flush cycle is already consumed by the drop.
    assign w_drop_next = w_outstanding - PW'(imem_rvalid);

    fetch_buffer #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_buf (
        .clk           (clk),
        .rst           (rst),
        .i_alloc       (w_alloc),
        .i_alloc_pc    (pc_in),
        .i_fill        (w_fill),
        .i_fill_data   (imem_rdata),
        .i_pop         (w_pop),
        .i_flush       (w_flush),
        .o_rd_filled   (w_rd_filled),
        .o_rd_pc       (instr_pc),
        .o_rd_data     (instr),
        .o_occupancy   (w_occupancy),
        .o_outstanding (w_outstanding)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= RUN;
            r_drop_cnt <= '0;
        end else begin
            unique case (r_state)
                RUN: begin
                    if (flush) begin
                        r_drop_cnt <= w_drop_next;
                        r_state    <= (w_drop_next != '0) ? DRAIN : RUN;
                    end
                end
                DRAIN: begin
                    if (imem_rvalid) begin
                        r_drop_cnt <= r_drop_cnt - PW'(1);
                        if (r_drop_cnt == PW'(1))
                            r_state <= RUN;
                    end
                end
            endcase
        end
    end

`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] r_stall_full_cnt;
    logic [31:0] r_drop_cnt_total;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_full_cnt <= '0;
            r_drop_cnt_total <= '0;
        end else begin
            if (pc_valid && w_full && (r_stall_full_cnt != '1))
                r_stall_full_cnt <= r_stall_full_cnt + 32'd1;
            if (!w_run && imem_rvalid && (r_drop_cnt_total != '1))
                r_drop_cnt_total <= r_drop_cnt_total + 32'd1;
        end
    end

    assign stall_full_cnt = r_stall_full_cnt;
    assign drop_cnt_total = r_drop_cnt_total;
`endif

`ifndef SYNTHESIS
    a_rvalid_outstanding: assert property (
        @(posedge clk) disable iff (rst)
        (w_run && imem_rvalid) |-> (w_outstanding != '0)
    );
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: queue-based reference model,
// in-order memory model with configurable latency and grant pattern.
module tb_instr_fetch_unit;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_in;
    logic        pc_valid;
    logic        pc_ready;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] stall_full_cnt;
    logic [31:0] drop_cnt_total;
`endif

    instr_fetch_unit #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
`ifdef IFETCH_PERF_CNT_EN
        .stall_full_cnt (stall_full_cnt),
        .drop_cnt_total (drop_cnt_total),
`endif
        .pc_in       (pc_in),
        .pc_valid    (pc_valid),
        .pc_ready    (pc_ready),
        .flush       (flush),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        bit          filled;
    } ment_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    ment_t       mq[$];
    mreq_t       mpend[$];
    bit          m_drain = 0;
    int          m_drop = 0;
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          lat = 1;
    int          gnt_mode = 0;
    bit          flush_on_rv = 0;
    logic [31:0] redir_pc = '0;
    int          grants = 0;
    int          pops = 0;
    int          dut_grants = 0;
    logic [31:0] first_pc = '1;
    bit          first_armed = 0;
    bit          o_valid = 0;
    bit          o_req = 0;

    function automatic logic [31:0] memf(logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h00C0FFEE;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic rst_chk(string tag);
        chk({tag, "_valid"}, instr_valid, 0);
        chk({tag, "_req"}, imem_req, 0);
        chk({tag, "_pc_ready"}, pc_ready, 0);
        chk({tag, "_instr"}, instr, 0);
        chk({tag, "_instr_pc"}, instr_pc, 0);
    endtask

    // One clock: drive in the low phase, check before the edge, update after.
    task automatic cycle();
        bit          e_req;
        bit          e_ready;
        bit          e_valid;
        bit          rv;
        bit          grant_now;
        logic [31:0] addr_now;
        int          due;
        int          unf;

        rv = (mpend.size() > 0) && (mpend[0].due <= cyc);
        imem_rvalid = rv;
        imem_rdata  = rv ? memf(mpend[0].addr) : $urandom;
        case (gnt_mode)
            0:       imem_gnt = 1'b1;
            1:       imem_gnt = ~cyc[0];
            default: imem_gnt = ($urandom_range(0, 2) != 0);
        endcase
        if (flush_on_rv && rv) begin
            flush       = 1'b1;
            pc_in       = redir_pc;
            flush_on_rv = 0;
        end

        e_req   = !m_drain && pc_valid && !flush && (mq.size() < DEPTH);
        e_ready = e_req && imem_gnt;
        e_valid = !flush && (mq.size() > 0) && mq[0].filled;

        #2;
        chk("imem_req", imem_req, e_req);
        chk("pc_ready", pc_ready, e_ready);
        if (e_req) chk("imem_addr", imem_addr, pc_in);
        chk("instr_valid", instr_valid, e_valid);
        if (e_valid) begin
            chk("instr_pc", instr_pc, mq[0].pc);
            chk("instr", instr, mq[0].data);
        end
        o_valid = instr_valid;
        o_req   = imem_req;
        if (pc_ready) dut_grants++;
        if (instr_valid && instr_ready) begin
            pops++;
            if (first_armed) begin
                first_pc    = instr_pc;
                first_armed = 0;
            end
        end
        grant_now = imem_req && imem_gnt;
        addr_now  = imem_addr;

        @(posedge clk);
        #1;
        if (rv) void'(mpend.pop_front());
        if (grant_now) begin
            due = cyc + lat;
            if (mpend.size() > 0 && mpend[$].due >= due) due = mpend[$].due + 1;
            mpend.push_back('{addr_now, due});
        end

        if (m_drain) begin
            if (rv) begin
                m_drop--;
                if (m_drop == 0) m_drain = 0;
            end
        end else if (flush) begin
            unf = 0;
            foreach (mq[i]) if (!mq[i].filled) unf++;
            m_drop = unf - int'(rv);
            mq.delete();
            m_drain = (m_drop != 0);
        end else begin
            if (rv) begin
                for (int i = 0; i < mq.size(); i++) begin
                    if (!mq[i].filled) begin
                        mq[i].data   = memf(mq[i].pc);
                        mq[i].filled = 1;
                        break;
                    end
                end
            end
            if (e_valid && instr_ready) void'(mq.pop_front());
            if (e_ready) begin
                mq.push_back('{pc_in, 32'h0, 1'b0});
                grants++;
            end
        end

        if (e_ready) pc_in = pc_in + 32'd1;
        flush = 1'b0;
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain_all();
        pc_valid    = 1'b0;
        instr_ready = 1'b1;
        for (int k = 0; k < 60 && (mq.size() != 0 || mpend.size() != 0 || m_drain); k++)
            cycle();
        chk("drain_timeout", (mq.size() == 0 && mpend.size() == 0 && !m_drain), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int          thr;
        int          g0;
        int          p0;
        logic [31:0] restart_pc;
`ifdef IFETCH_PERF_CNT_EN
        logic [31:0] pc0;
`endif

        rst         = 1'b1;
        pc_in       = '0;
        pc_valid    = 1'b1;
        flush       = 1'b0;
        imem_gnt    = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        instr_ready = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        rst_chk("reset");
        @(negedge clk);
        rst = 1'b0;

        // Streaming with single-cycle memory
        lat = 1;
        gnt_mode = 0;
        first_armed = 1;
        thr = 0;
        for (int k = 0; k < 40; k++) begin
            cycle();
            if (k >= 10 && o_valid) thr++;
        end
        chk("stream_first_pc", first_pc, 32'h0);
        chk("stream_throughput", thr, 30);

        // Decode stalled: buffer fills to DEPTH
        drain_all();
        instr_ready = 1'b0;
        pc_valid = 1'b1;
        g0 = dut_grants;
`ifdef IFETCH_PERF_CNT_EN
        pc0 = stall_full_cnt;
`endif
        repeat (10) cycle();
        chk("full_grants", dut_grants - g0, 4);
        chk("full_req", o_req, 0);
`ifdef IFETCH_PERF_CNT_EN
        chk("stall_full_cnt", stall_full_cnt - pc0, 6);
`endif
        instr_ready = 1'b1;
        repeat (20) cycle();

        // Flush with three outstanding
        drain_all();
        lat = 6;
        pc_in = 32'h8;
        pc_valid = 1'b1;
        repeat (3) cycle();
`ifdef IFETCH_PERF_CNT_EN
        pc0 = drop_cnt_total;
`endif
        pc_in = 32'h20;
        flush = 1'b1;
        cycle();
        chk("flush_valid", o_valid, 0);
        chk("flush_req", o_req, 0);
        cycle();
        chk("drain_req", o_req, 0);
        first_pc = '1;
        first_armed = 1;
        repeat (25) cycle();
        chk("redirect_pc", first_pc, 32'h20);
`ifdef IFETCH_PERF_CNT_EN
        chk("drop_cnt_total", drop_cnt_total - pc0, 3);
`endif

        // Flush coincident with a response, two outstanding
        drain_all();
        lat = 3;
        pc_in = 32'h30;
        pc_valid = 1'b1;
        repeat (2) cycle();
        pc_valid = 1'b0;
        redir_pc = 32'h40;
        flush_on_rv = 1;
        for (int k = 0; k < 10 && flush_on_rv; k++) cycle();
        chk("flush_rv_seen", flush_on_rv, 0);
        pc_valid = 1'b1;
        first_pc = '1;
        first_armed = 1;
        cycle();
        chk("drop_one_req", o_req, 0);
        cycle();
        chk("drop_one_resume", o_req, 1);
        repeat (10) cycle();
        chk("redirect_pc2", first_pc, 32'h40);

        // Toggling grant, latency 3, random decode stalls
        drain_all();
        gnt_mode = 1;
        lat = 3;
        g0 = grants;
        p0 = pops;
        pc_in = 32'h100;
        for (int k = 0; k < 60; k++) begin
            pc_valid = 1'b1;
            instr_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        drain_all();
        chk("toggle_exactly_once", pops - p0, grants - g0);

        // Random traffic with random flushes and latencies
        gnt_mode = 2;
        for (int k = 0; k < 300; k++) begin
            pc_valid = ($urandom_range(0, 4) != 0);
            instr_ready = ($urandom_range(0, 3) != 0);
            lat = $urandom_range(1, 4);
            if ($urandom_range(0, 19) == 0) begin
                flush = 1'b1;
                pc_in = $urandom;
            end
            cycle();
        end
        drain_all();
        gnt_mode = 0;

        // Asynchronous reset mid-burst
        lat = 2;
        pc_valid = 1'b1;
        instr_ready = 1'b1;
        repeat (6) cycle();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        rst_chk("async_rst");
        mq.delete();
        mpend.delete();
        m_drain = 0;
        m_drop = 0;
        imem_rvalid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        rst_chk("rst_hold");
        rst = 1'b0;
        restart_pc = pc_in;
        first_pc = '1;
        first_armed = 1;
        repeat (15) cycle();
        chk("restart_pc", first_pc, restart_pc);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
